arb_mux_rr: RTL and testbench
=============================

# arb_mux_rr

Parametrised, registered N-input multiplexer with valid/ready handshake on every input and on the output, selecting either by an explicit select port or by round-robin arbitration. It replaces fixed-width combinational 8:1 selection wherever several producers feed one consumer, such as writeback-source and memory-request funnelling in the pipeline. One beat is transferred per cycle at full throughput with one cycle of latency.

## Interface
- `WIDTH`, 16, data bits per channel
- `NUM_IN`, 8, number of input channels (≥2)
- `SEL_W`, `$clog2(NUM_IN)`, select/index width
---
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `mode`  in  1  0 = fixed (use `sel`), 1 = round-robin
- `sel`  in  SEL_W  channel index in fixed mode
- `in_data`  in  NUM_IN*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- `in_valid`  in  NUM_IN  per-channel valid
- `in_last`  in  NUM_IN  per-channel end-of-packet (used only with lock feature)
- `in_ready`  out  NUM_IN  per-channel ready, at most one bit high
- `out_data`  out  WIDTH  registered data
- `out_src`  out  SEL_W  index of channel that produced `out_data`
- `out_valid`  out  1  output register holds a beat
- `out_ready`  in  1  consumer accepts

## Operation
- `load_en = !out_valid | out_ready`
- Grant `g`: fixed mode gives `g = sel`. Round-robin mode gives the first i with `in_valid[i]`, searching from `ptr+1` upward and wrapping modulo NUM_IN. With no valid request there is no grant.
- `in_ready[i] = load_en & in_valid[i] & (i == g)`; transfer on channel i when `in_valid[i] & in_ready[i]`.
- On transfer: `out_data <= in_data[g]`, `out_src <= g`, `out_valid <= 1`. In round-robin mode, `ptr <= g`.
- With `out_valid & out_ready` and no new transfer: `out_valid <= 0`. Data and src hold their last values.
- `sel` ≥ NUM_IN (non-power-of-2 NUM_IN): no grant, all `in_ready` low.
- `ptr` is not updated in fixed mode.
- `mode` and `sel` are sampled combinationally each cycle, so a change takes effect for the current cycle's grant.
- Reset values: `out_valid=0`, `out_data=0`, `out_src=0`, `ptr=NUM_IN-1` (channel 0 has first priority), lock state IDLE. `in_ready` is all-zero during reset.
- Reset mid-packet: output beat discarded, lock released, pointer restored.

## Timing
- Latency: input transfer in cycle N gives `out_valid` in N+1.
- Throughput: one beat per cycle while `out_ready` is high. Back-to-back grants can go to different channels.
- Combinational paths: `in_valid`, `mode`, `sel`, `out_ready` → `in_ready`. No path from input to output data.
- Simultaneous output drain and input load: the new beat replaces the old, and `out_valid` stays 1.
- Stall (`out_valid & !out_ready`): all `in_ready` low and the output register is held stable.

## Configuration
- `ARB_MUX_LOCK_EN` defined: two-state lock FSM, IDLE/LOCKED.
  - IDLE→LOCKED on a transfer with `in_last[g]=0`, latching `lock_ch <= g`.
  - While LOCKED, `g = lock_ch` regardless of `mode`, `sel` and other valids.
  - LOCKED→IDLE on a transfer with `in_last[lock_ch]=1`.
  - The round-robin pointer updates only at the IDLE→... transfer that starts a packet.
- Undefined: `in_last` is ignored, no lock state exists, and the grant is re-evaluated every cycle.

## Structure
- Shared package/defines file `arb_mux_defs`: `MODE_FIXED=1'b0`, `MODE_RR=1'b1`, `LOCK_IDLE`/`LOCK_HELD` encodings.
- Sub-module `rr_pick` (combinational): inputs `req[NUM_IN]` and `ptr`; outputs `gnt_idx` and `gnt_vld`. It contains the rotate-priority search.
- Top holds the output register, pointer, lock FSM and ready generation.

## Test plan (WIDTH=16, NUM_IN=8)
- Fixed mode, `sel=5`, `in_valid=8'hFF`, channel 5 data 16'hA5A5, `out_ready=1` → `in_ready=8'h20`; next cycle `out_data=16'hA5A5`, `out_src=5`.
- Round-robin after reset, all valid, `out_ready=1` for 9 cycles → `out_src` sequence 0,1,2,3,4,5,6,7,0.
- Round-robin, only channels 2 and 6 valid → grants alternate 2,6,2,6. Dropping ch6 valid gives 2,2,2.
- Backpressure: `out_ready=0` with output full → `in_ready=0`, `out_data` stable 4 cycles. On `out_ready=1`, a new beat loads in the same cycle.
- `ARB_MUX_LOCK_EN`: ch3 sends 3 beats (`in_last` on the 3rd) while ch4 is valid → `out_src`=3,3,3 then 4.
- Assert `rst` while `out_valid=1` and LOCKED → next cycle `out_valid=0`. With all valid in round-robin mode, the first grant is 0.

Source files
------------

// File: rtl/arb_mux_defs.sv
// arb_mux_defs -- shared definitions for the arb_mux_rr block.
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input
//   lock_state_t         : packet-lock FSM states (used when ARB_MUX_LOCK_EN is defined)
package arb_mux_defs;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      LOCK_IDLE = 1'b0,
      LOCK_HELD = 1'b1
   } lock_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick -- combinational rotate-priority search.
// Returns the first asserted request at or after ptr+1, wrapping modulo NUM_IN.
// Ports:
//   req     in  NUM_IN  request vector
//   ptr     in  SEL_W   index of the most recent winner
//   gnt_idx out SEL_W   winning index (0 when gnt_vld is low)
//   gnt_vld out 1       at least one request present
module rr_pick #(
   parameter int NUM_IN = 8,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [SEL_W-1:0]  gnt_idx,
   output logic              gnt_vld
);

   int idx;

   // Walk from the farthest candidate back to the nearest so the nearest
   // requester after ptr is the last one written.
   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      for (int k = NUM_IN; k >= 1; k--) begin
         idx = (int'(ptr) + k) % NUM_IN;
         if (req[idx]) begin
            gnt_idx = SEL_W'(idx);
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_mux_rr.sv
// arb_mux_rr -- registered N:1 multiplexer with valid/ready on every channel,
// selecting by explicit index (mode=0) or round-robin arbitration (mode=1).
// One beat per cycle, one cycle latency.
// Optional feature macro: ARB_MUX_LOCK_EN -- holds the grant on one channel
// from the first beat of a packet until its in_last beat.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   mode       0 = fixed (use sel), 1 = round-robin
//   sel        channel index in fixed mode
//   in_data    NUM_IN packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_last    per-channel end-of-packet (lock feature only)
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered data
//   out_src    channel index that produced out_data
//   out_valid  output register holds a beat
//   out_ready  consumer accepts
import arb_mux_defs::*;

module arb_mux_rr #(
   parameter int WIDTH  = 16,
   parameter int NUM_IN = 8,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   input  logic [NUM_IN-1:0]       in_last,
   output logic [NUM_IN-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_src,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic             load_en;
   logic             xfer;
   logic             ptr_upd;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] rr_idx;
   logic             rr_vld;
   logic [SEL_W-1:0] g;
   logic             g_vld;

   rr_pick #(
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_pick (
      .req     (in_valid),
      .ptr     (ptr),
      .gnt_idx (rr_idx),
      .gnt_vld (rr_vld)
   );

   assign load_en = !out_valid || out_ready;

`ifdef ARB_MUX_LOCK_EN
   lock_state_t      lock_state;
   lock_state_t      lock_next;
   logic [SEL_W-1:0] lock_ch;
   logic             locked;

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_state <= LOCK_IDLE;
         lock_ch    <= '0;
      end else begin
         lock_state <= lock_next;
         if (xfer && lock_state == LOCK_IDLE)
            lock_ch <= g;
      end
   end

   always_comb begin
      lock_next = lock_state;
      case (lock_state)
         LOCK_IDLE: if (xfer && !in_last[g])      lock_next = LOCK_HELD;
         LOCK_HELD: if (xfer && in_last[lock_ch]) lock_next = LOCK_IDLE;
         default:                                 lock_next = LOCK_IDLE;
      endcase
   end

   always_comb begin
      locked = (lock_state == LOCK_HELD);
   end

   // The pointer only advances on the beat that opens a packet.
   assign ptr_upd = xfer && (mode == MODE_RR) && !locked;
`else
   logic unused_last;
   assign unused_last = ^in_last;
   assign ptr_upd     = xfer && (mode == MODE_RR);
`endif

   // Grant selection; an out-of-range sel (non-power-of-2 NUM_IN) yields no grant.
   always_comb begin
      g     = sel;
      g_vld = ({1'b0, sel} < (SEL_W+1)'(NUM_IN));
      if (mode == MODE_RR) begin
         g     = rr_idx;
         g_vld = rr_vld;
      end
`ifdef ARB_MUX_LOCK_EN
      if (locked) begin
         g     = lock_ch;
         g_vld = 1'b1;
      end
`endif
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NUM_IN; i++)
         in_ready[i] = !rst && load_en && g_vld && in_valid[i] && (g == SEL_W'(i));
   end

   assign xfer = |in_ready;

   // Output register stage
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         ptr       <= SEL_W'(NUM_IN-1);
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(g)*WIDTH +: WIDTH];
            out_src   <= g;
            if (ptr_upd)
               ptr <= g;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux_rr.sv
// tb_arb_mux_rr -- directed self-checking bench for arb_mux_rr (WIDTH=16, NUM_IN=8).
// Expected beats are pushed to a scoreboard queue when stimulus is driven and
// popped when the output register is sampled. Build with or without ARB_MUX_LOCK_EN.
module tb_arb_mux_rr;

   localparam int WIDTH  = 16;
   localparam int NUM_IN = 8;
   localparam int SEL_W  = 3;
`ifdef ARB_MUX_LOCK_EN
   localparam bit LOCK_ON = 1'b1;
`else
   localparam bit LOCK_ON = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    mode;
   logic [SEL_W-1:0]        sel;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_last;
   logic [NUM_IN-1:0]       in_ready;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_src;
   logic                    out_valid;
   logic                    out_ready;

   arb_mux_rr #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic [SEL_W-1:0] s;
   } beat_t;

   beat_t            sb[$];
   logic [WIDTH-1:0] dat [NUM_IN];
   logic [WIDTH-1:0] hold_data;
   logic [SEL_W-1:0] hold_src;
   logic             a5 = 1'b0;
   int               seed = 0;
   int               errors = 0;
   int               checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive inputs, check in_ready, then check the output register.
   // exp_ch < 0 means no transfer is expected this cycle.
   task automatic step(input string tag, input logic m, input logic [SEL_W-1:0] s,
                       input logic [7:0] v, input logic [7:0] l, input logic ordy,
                       input int exp_ch, input logic exp_ov);
      beat_t b;
      seed++;
      for (int i = 0; i < NUM_IN; i++)
         dat[i] = {8'(seed), 4'(i), 4'h9};
      if (a5) dat[5] = 16'hA5A5;
      for (int i = 0; i < NUM_IN; i++)
         in_data[i*WIDTH +: WIDTH] = dat[i];
      mode = m; sel = s; in_valid = v; in_last = l; out_ready = ordy;
      #1;
      chk({tag, "/in_ready"}, 32'(in_ready), (exp_ch < 0) ? 32'h0 : (32'h1 << exp_ch));
      if (exp_ch >= 0) sb.push_back('{d: dat[exp_ch], s: SEL_W'(exp_ch)});
      @(posedge clk); #1;
      chk({tag, "/out_valid"}, 32'(out_valid), 32'(exp_ov));
      if (exp_ch >= 0) begin
         if (sb.size() == 0) begin
            chk({tag, "/sb_empty"}, 32'(sb.size()), 32'd1);
         end else begin
            b = sb.pop_front();
            chk({tag, "/out_data"}, 32'(out_data), 32'(b.d));
            chk({tag, "/out_src"},  32'(out_src),  32'(b.s));
            hold_data = b.d;
            hold_src  = b.s;
         end
      end else if (exp_ov) begin
         chk({tag, "/hold_data"}, 32'(out_data), 32'(hold_data));
         chk({tag, "/hold_src"},  32'(out_src),  32'(hold_src));
      end
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; sel = '0; in_data = '0;
      in_valid = '0; in_last = '1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 8'hFF; mode = 1'b1;
      #1;
      chk("reset/in_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk("reset/out_valid", 32'(out_valid), 32'h0);
      chk("reset/out_data",  32'(out_data),  32'h0);
      chk("reset/out_src",   32'(out_src),   32'h0);
      rst = 1'b0;

      // fixed select of channel 5
      a5 = 1'b1;
      step("fixed5", 1'b0, 3'd5, 8'hFF, 8'hFF, 1'b1, 5, 1'b1);
      a5 = 1'b0;

      // round-robin from reset pointer: 0..7 then 0 (fixed mode left ptr alone)
      for (int k = 0; k < 9; k++)
         step("rr_all", 1'b1, 3'd0, 8'hFF, 8'hFF, 1'b1, k % 8, 1'b1);

      // only channels 2 and 6 requesting
      step("rr26", 1'b1, 3'd0, 8'h44, 8'hFF, 1'b1, 2, 1'b1);
      step("rr26", 1'b1, 3'd0, 8'h44, 8'hFF, 1'b1, 6, 1'b1);
      step("rr26", 1'b1, 3'd0, 8'h44, 8'hFF, 1'b1, 2, 1'b1);
      step("rr26", 1'b1, 3'd0, 8'h44, 8'hFF, 1'b1, 6, 1'b1);
      for (int k = 0; k < 3; k++)
         step("rr2", 1'b1, 3'd0, 8'h04, 8'hFF, 1'b1, 2, 1'b1);

      // backpressure: full output held for 4 cycles, then drain and load together
      for (int k = 0; k < 4; k++)
         step("stall", 1'b1, 3'd0, 8'hFF, 8'hFF, 1'b0, -1, 1'b1);
      step("release", 1'b1, 3'd0, 8'hFF, 8'hFF, 1'b1, 3, 1'b1);

      // drain with no requests, then fixed select of an idle channel
      step("drain", 1'b1, 3'd0, 8'h00, 8'hFF, 1'b1, -1, 1'b0);
      step("fixed_idle", 1'b0, 3'd1, 8'h10, 8'hFF, 1'b1, -1, 1'b0);

      // mode change takes effect immediately; fixed grant leaves ptr at 3
      step("fixed6", 1'b0, 3'd6, 8'hFF, 8'hFF, 1'b1, 6, 1'b1);
      step("rr_after_fixed", 1'b1, 3'd0, 8'hFF, 8'hFF, 1'b1, 4, 1'b1);

      // packet from ch3 with ch4 competing (pointer back to 7 after reset)
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      step("pkt_b1", 1'b1, 3'd0, 8'h18, 8'h00, 1'b1, 3, 1'b1);
      step("pkt_b2", 1'b0, 3'd4, 8'h18, 8'h00, 1'b1, LOCK_ON ? 3 : 4, 1'b1);
      step("pkt_b3", 1'b1, 3'd0, 8'h18, 8'h08, 1'b1, LOCK_ON ? 3 : 4, 1'b1);
      step("pkt_after", 1'b1, 3'd0, 8'h18, 8'hFF, 1'b1, LOCK_ON ? 4 : 3, 1'b1);

      // start another packet, then reset with the output full
      step("pkt2_b1", 1'b1, 3'd0, 8'h18, 8'h00, 1'b1, LOCK_ON ? 3 : 4, 1'b1);
      rst = 1'b1; mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b0;
      #1;
      chk("midrst/in_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk("midrst/out_valid", 32'(out_valid), 32'h0);
      rst = 1'b0;
      step("post_reset", 1'b1, 3'd0, 8'hFF, 8'hFF, 1'b1, 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
